// File: rtl/div_unit_32bit_pkg.sv
// Shared definitions for the RV32M iterative divider: FUNCT3 encodings, FSM states,
// forced special-case results and a conditional negation helper.
package div_unit_32bit_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit_32bit_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left and
// subtract the divisor with a 33-bit trial, keeping the result if non-negative.
module div_step_32bit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // trial subtraction and restore select
  always_comb begin
    shifted_s = {rem_i, quo_i[XLEN-1]};
    trial_s   = shifted_s - {1'b0, dvsr_i};
    if (!trial_s[XLEN]) begin
      rem_o = trial_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit_32bit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider, 33 edges from accept to DONE.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module div_unit_32bit
  import div_unit_32bit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [XLEN-1:0]   step_rem_s, step_quo_s, q_fix_s, r_fix_s;
  logic              signed_op_s, d1_neg_s, d2_neg_s, div_zero_s, sig_ovf_s, special_s;
  logic              unused_funct3_s;

  assign unused_funct3_s = FUNCT3[2];
  assign signed_op_s = !((FUNCT3[1:0] == F3_DIVU[1:0]) || (FUNCT3[1:0] == F3_REMU[1:0]));
  assign d1_neg_s    = signed_op_s & DATA1[XLEN-1];
  assign d2_neg_s    = signed_op_s & DATA2[XLEN-1];
  assign div_zero_s  = (DATA2 == 32'd0);
  assign sig_ovf_s   = signed_op_s & (DATA1 == SIGNED_MIN) & (DATA2 == 32'hFFFF_FFFF);
  assign special_s   = div_zero_s | sig_ovf_s;

  div_step_32bit #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem_s),
    .quo_o  (step_quo_s)
  );

  // state and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      dvnd_q   <= 32'd0;
      result_q <= 32'd0;
      op_q     <= 2'b00;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      dvnd_q   <= dvnd_d;
      result_q <= result_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
`ifdef DIV_EARLY_OUT_EN
          state_d = special_s ? S_FINISH : S_CALC;
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sign correction first; forced special-case values then override the datapath.
  assign q_fix_s = neg_if(quo_q, qneg_q);
  assign r_fix_s = neg_if(rem_q, rneg_q);

  // operand capture, iteration and result/handshake outputs
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    dvnd_d   = dvnd_q;
    result_d = result_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          rem_d  = 32'd0;
          quo_d  = neg_if(DATA1, d1_neg_s);
          dvsr_d = neg_if(DATA2, d2_neg_s);
          dvnd_d = DATA1;
          op_d   = FUNCT3[1:0];
          qneg_d = d1_neg_s ^ d2_neg_s;
          rneg_d = d1_neg_s;
          dz_d   = div_zero_s;
          ovf_d  = sig_ovf_s;
          cnt_d  = '0;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FINISH: begin
        if (dz_q) begin
          result_d = ((op_q == F3_DIV[1:0]) || (op_q == F3_DIVU[1:0])) ? DIV_BY_ZERO_Q : dvnd_q;
        end else if (ovf_q) begin
          result_d = ((op_q == F3_DIV[1:0]) || (op_q == F3_DIVU[1:0])) ? SIGNED_MIN : 32'd0;
        end else begin
          result_d = ((op_q == F3_DIV[1:0]) || (op_q == F3_DIVU[1:0])) ? q_fix_s : r_fix_s;
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
